mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- CPU-side master for the byte-addressed ram256x8 MFA/MOC handshake.
- Takes a single-cycle request (read/write, byte/halfword/word) and drives MFA, ReadWrite, Address, dSize and write data to the RAM.
- Waits for MOC, captures and extends read data, and returns a one-cycle done pulse with an error flag.
- Sits between the datapath control unit and the RAM.

Parameters:
- ADDR_W, 8, RAM address width; the RAM holds 2^ADDR_W bytes.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles to wait for MOC. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  start a transfer; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write (same polarity as the RAM's ReadWrite).
- addr  in  ADDR_W  byte address of the most significant byte.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- ld_signed  in  1  on reads, sign-extend byte/halfword when 1, zero-extend when 0.
- wdata  in  32  write data, right-justified.
- busy  out  1  high from the cycle after req is accepted through DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid while done=1.
- rdata  out  32  last successful read result; holds its value otherwise.
- mfa  out  1  RAM Enable.
- mem_rw  out  1  RAM ReadWrite.
- mem_addr  out  ADDR_W  RAM Address.
- mem_dsize  out  2  RAM dSize.
- mem_wdata  out  32  RAM DataIn.
- mem_rdata  in  32  RAM DataOut.
- moc  in  1  RAM MOC; may be combinational from mfa.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, err, mfa = 0; mem_rw=1; mem_addr, mem_dsize, mem_wdata, rdata = 0. A transfer in progress is abandoned; mfa drops immediately.
- Request capture: in IDLE with req=1, latch rw, addr, size, ld_signed and wdata. req in any other state is ignored and not queued.
- Legality check at capture: illegal if size=11, or if addr + bytes > 2^ADDR_W, where bytes = 1/2/4. Illegal requests go straight to DONE with err=1; mfa never asserts.
- IDLE -> SETUP (legal request): drive mem_addr, mem_rw, mem_dsize and mem_wdata; mfa=0. Lasts one cycle for address/data setup.
- SETUP -> ACCESS: mfa=1; all mem_* outputs held stable.
- ACCESS: on each edge with moc=1, go to RELEASE.
  - Read: rdata = mem_rdata[7:0] (byte) or mem_rdata[15:0] (halfword), sign- or zero-extended per ld_signed; word reads take mem_rdata[31:0].
- RELEASE: mfa=0. On an edge with moc=0, go to DONE. Stays in RELEASE while moc=1.
- DONE: done=1, err per the transfer, busy=1; next state is IDLE, where busy=0.
- Writes never modify rdata. Failed transfers leave rdata unchanged.
- Minimum latency with a combinational responder: req sampled at edge 0; done high in the cycle after edge 3. Back-to-back requests: next req accepted on the first IDLE cycle, i.e. one transfer per 5 cycles.
- Byte order is big-endian: mem_addr points at the MSB; the RAM handles the lane split.
- mem_* outputs are registered and hold their last values in IDLE/DONE. Only mfa qualifies them.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS.
  - If TIMEOUT_CYCLES ACCESS cycles pass without moc, go to RELEASE with err latched to 1 and rdata unchanged.
  - The counter is ADDR_W-independent, sized by $clog2(TIMEOUT_CYCLES+1).
- Undefined: ACCESS waits for moc indefinitely; no counter logic.

Test Plan:
- Write word 0xA00000AB at addr 0x00, then read word at 0x00 -> mfa asserts exactly one cycle after mem_addr is valid; rdata=0xA00000AB; err=0; done for one cycle each transfer; 5-cycle spacing.
- Write halfword 0xCAFE at 0x08, then read byte at 0x08 with ld_signed=1, then ld_signed=0 -> rdata=0xFFFFFFCA, then 0x000000CA.
- Read halfword 0x08 with ld_signed=1 after the above -> rdata=0xFFFFCAFE. Then word read at 0x08 after byte write 0xFE at 0x0A -> rdata=0xCAFEFE??, where ?? is the preloaded byte at 0x0B.
- size=11, then word at addr 0xFE -> done+err within 2 cycles; mfa stays 0; rdata unchanged.
- Responder delays moc by 6 cycles and holds it 3 cycles after mfa drops -> busy held, done only after moc=0. Deassert reset_n mid-ACCESS -> mfa, busy = 0 asynchronously; state IDLE.
- MEM_TIMEOUT_EN with moc tied 0 -> after 16 ACCESS cycles: mfa=0, done=1, err=1. Without the macro: still busy after 100 cycles.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator: CPU-side MFA/MOC master for a byte-addressed big-endian RAM (MEM_TIMEOUT_EN bounds ACCESS).
// Latency: req sampled at edge 0, done pulses in the cycle after edge 3 with a combinational MOC responder.
// Backpressure: req is only sampled in IDLE; requests while busy are dropped, and MOC stalls ACCESS/RELEASE.
module mem_initiator #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              ld_signed,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mfa,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_dsize,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              moc
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, state_nxt;
    logic            ld_sgn;
    logic            err_q;
    logic            tmo;
    logic            illegal;
    logic [ADDR_W:0] nbytes;
    logic [ADDR_W:0] end_addr;
    logic [31:0]     rd_ext;

    // A transfer is illegal if its last byte would fall past the top of the RAM.
    always_comb begin
        nbytes = '0;
        case (size)
            2'b00:   nbytes = (ADDR_W+1)'(1);
            2'b01:   nbytes = (ADDR_W+1)'(2);
            default: nbytes = (ADDR_W+1)'(4);
        endcase
        end_addr = {1'b0, addr} + nbytes;
        illegal  = (size == 2'b11) || (end_addr > MEM_BYTES);
    end

    always_comb begin
        rd_ext = mem_rdata;
        case (mem_dsize)
            2'b00:   rd_ext = {{24{ld_sgn & mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01:   rd_ext = {{16{ld_sgn & mem_rdata[15]}}, mem_rdata[15:0]};
            default: rd_ext = mem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo = (state == ACCESS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !moc) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Without the timeout ACCESS waits for MOC forever.
    assign tmo = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = illegal ? DONE : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (moc || tmo) state_nxt = RELEASE;
            RELEASE: if (!moc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so the RAM sees glitch-free strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mfa       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_q     <= 1'b0;
            ld_sgn    <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_dsize <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            mfa  <= (state_nxt == ACCESS);
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            if (state == IDLE && req) begin
                err_q <= illegal;
                if (!illegal) begin
                    mem_rw    <= rw;
                    mem_addr  <= addr;
                    mem_dsize <= size;
                    mem_wdata <= wdata;
                    ld_sgn    <= ld_signed;
                end
            end
            if (state == ACCESS) begin
                if (moc) begin
                    if (mem_rw) rdata <= rd_ext;
                end else if (tmo) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign err = done & err_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator against a behavioural big-endian 256-byte RAM responder.
`timescale 1ns/1ps
module tb_mem_initiator;

    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req, rw, ld_signed;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        busy, done, err, mfa, mem_rw, moc;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_dsize;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mode   = 0;   // 0: combinational moc, 1: delayed moc, 2: moc tied low

    logic [7:0] ram [256];
    logic       ram_ready = 1'b0;
    logic       moc_seq = 1'b0;
    int         mfa_cnt = 0;
    int         hold_cnt = 0;

    int          x_lat, x_mfa_k, x_done_cyc;
    logic        x_setup_ok, x_err, x_pulse_ok, x_busy_ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .addr(addr), .size(size),
        .ld_signed(ld_signed), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mfa(mfa), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_dsize(mem_dsize), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .moc(moc)
    );

    // RAM preloads ram[i] = i, then takes big-endian writes on the edge that completes ACCESS.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
            ram_ready <= 1'b1;
        end else if (mfa && moc && !mem_rw) begin
            case (mem_dsize)
                2'b00: ram[mem_addr] <= mem_wdata[7:0];
                2'b01: begin
                    ram[mem_addr]       <= mem_wdata[15:8];
                    ram[mem_addr+8'd1]  <= mem_wdata[7:0];
                end
                default: begin
                    ram[mem_addr]       <= mem_wdata[31:24];
                    ram[mem_addr+8'd1]  <= mem_wdata[23:16];
                    ram[mem_addr+8'd2]  <= mem_wdata[15:8];
                    ram[mem_addr+8'd3]  <= mem_wdata[7:0];
                end
            endcase
        end
    end

    always_comb begin
        mem_rdata = '0;
        case (mem_dsize)
            2'b00:   mem_rdata = {24'h0, ram[mem_addr]};
            2'b01:   mem_rdata = {16'h0, ram[mem_addr], ram[mem_addr+8'd1]};
            default: mem_rdata = {ram[mem_addr], ram[mem_addr+8'd1], ram[mem_addr+8'd2], ram[mem_addr+8'd3]};
        endcase
    end

    // Slow responder: moc rises 6 cycles after mfa and lingers 3 cycles after mfa drops.
    always @(posedge clk) begin
        if (mfa) begin
            mfa_cnt  <= mfa_cnt + 1;
            hold_cnt <= 2;
            if (mfa_cnt + 1 >= 6) moc_seq <= 1'b1;
        end else begin
            mfa_cnt <= 0;
            if (moc_seq) begin
                if (hold_cnt == 0) moc_seq <= 1'b0;
                else hold_cnt <= hold_cnt - 1;
            end
        end
    end

    assign moc = (mode == 0) ? mfa : (mode == 1) ? moc_seq : 1'b0;

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues one request from a negedge and follows it to done (bounded by budget cycles).
    task automatic do_xfer(input logic i_rw, input logic [7:0] a, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] wd, input int budget);
        req = 1'b1; rw = i_rw; addr = a; size = sz; ld_signed = sgn; wdata = wd;
        @(negedge clk);
        req = 1'b0; addr = ~a; wdata = 32'hDEAD_BEEF; ld_signed = ~sgn; rw = ~i_rw;
        x_lat = -1; x_mfa_k = -1; x_busy_ok = 1'b1; x_err = 1'b0; x_done_cyc = -1;
        x_setup_ok = (mem_addr === a) && (mfa === 1'b0);
        for (int k = 1; k <= budget; k++) begin
            if (mfa === 1'b1 && x_mfa_k < 0) x_mfa_k = k;
            if (busy !== 1'b1) x_busy_ok = 1'b0;
            if (done === 1'b1) begin
                x_lat = k; x_err = err; x_done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        x_pulse_ok = 1'b0;
        if (x_lat > 0) begin
            @(negedge clk);
            x_pulse_ok = (done === 1'b0) && (busy === 1'b0);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (mfa !== 1'b0) begin errors++; $display("FAIL reset_mfa: got %b want 0", mfa); end
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL reset_mem_rw: got %b want 1", mem_rw); end
        checks++; if ({mem_addr, mem_dsize, mem_wdata} !== 42'h0) begin
            errors++; $display("FAIL reset_mem_bus: got addr=%h dsize=%b wdata=%h want all 0", mem_addr, mem_dsize, mem_wdata);
        end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_word();
        int d1;
        do_xfer(1'b0, 8'h00, 2'b10, 1'b0, 32'hA000_00AB, 40);
        d1 = x_done_cyc;
        checks++; if (x_lat != 4) begin errors++; $display("FAIL wr_word_latency: got %0d want 4", x_lat); end
        checks++; if (x_mfa_k != 2) begin errors++; $display("FAIL wr_word_mfa_cycle: got %0d want 2", x_mfa_k); end
        checks++; if (x_setup_ok !== 1'b1) begin errors++; $display("FAIL wr_word_setup: got %b want 1", x_setup_ok); end
        checks++; if (x_err !== 1'b0) begin errors++; $display("FAIL wr_word_err: got %b want 0", x_err); end
        checks++; if (x_pulse_ok !== 1'b1) begin errors++; $display("FAIL wr_word_done_pulse: got %b want 1", x_pulse_ok); end
        checks++; if ({ram[0], ram[1], ram[2], ram[3]} !== 32'hA000_00AB) begin
            errors++; $display("FAIL wr_word_ram: got %h want a00000ab", {ram[0], ram[1], ram[2], ram[3]});
        end
        do_xfer(1'b1, 8'h00, 2'b10, 1'b0, 32'h0, 40);
        checks++; if (rdata !== 32'hA000_00AB) begin errors++; $display("FAIL rd_word_data: got %h want a00000ab", rdata); end
        checks++; if (x_pulse_ok !== 1'b1 || x_err !== 1'b0) begin
            errors++; $display("FAIL rd_word_done: got pulse=%b err=%b want 1 0", x_pulse_ok, x_err);
        end
        checks++; if (x_done_cyc - d1 != 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", x_done_cyc - d1); end
    endtask

    task automatic test_half_byte();
        do_xfer(1'b0, 8'h08, 2'b01, 1'b0, 32'h0000_CAFE, 40);
        checks++; if (x_err !== 1'b0 || x_lat != 4) begin errors++; $display("FAIL wr_half: got err=%b lat=%0d want 0 4", x_err, x_lat); end
        do_xfer(1'b1, 8'h08, 2'b00, 1'b1, 32'h0, 40);
        checks++; if (rdata !== 32'hFFFF_FFCA) begin errors++; $display("FAIL rd_byte_signed: got %h want ffffffca", rdata); end
        do_xfer(1'b1, 8'h08, 2'b00, 1'b0, 32'h0, 40);
        checks++; if (rdata !== 32'h0000_00CA) begin errors++; $display("FAIL rd_byte_unsigned: got %h want 000000ca", rdata); end
        do_xfer(1'b1, 8'h08, 2'b01, 1'b1, 32'h0, 40);
        checks++; if (rdata !== 32'hFFFF_CAFE) begin errors++; $display("FAIL rd_half_signed: got %h want ffffcafe", rdata); end
        do_xfer(1'b0, 8'h0A, 2'b00, 1'b0, 32'h1234_56FE, 40);
        checks++; if (rdata !== 32'hFFFF_CAFE) begin errors++; $display("FAIL write_keeps_rdata: got %h want ffffcafe", rdata); end
        do_xfer(1'b1, 8'h08, 2'b10, 1'b0, 32'h0, 40);
        checks++; if (rdata !== 32'hCAFE_FE0B) begin errors++; $display("FAIL rd_word_mixed: got %h want cafefe0b", rdata); end
    endtask

    task automatic test_illegal();
        do_xfer(1'b1, 8'h10, 2'b11, 1'b0, 32'h0, 10);
        checks++; if (x_lat != 1 || x_err !== 1'b1) begin errors++; $display("FAIL illegal_size: got lat=%0d err=%b want 1 1", x_lat, x_err); end
        checks++; if (x_mfa_k != -1) begin errors++; $display("FAIL illegal_size_mfa: got %0d want -1", x_mfa_k); end
        checks++; if (rdata !== 32'hCAFE_FE0B) begin errors++; $display("FAIL illegal_size_rdata: got %h want cafefe0b", rdata); end
        do_xfer(1'b1, 8'hFE, 2'b10, 1'b0, 32'h0, 10);
        checks++; if (x_lat != 1 || x_err !== 1'b1 || x_mfa_k != -1) begin
            errors++; $display("FAIL illegal_word_fe: got lat=%0d err=%b mfa_k=%0d want 1 1 -1", x_lat, x_err, x_mfa_k);
        end
        checks++; if (rdata !== 32'hCAFE_FE0B) begin errors++; $display("FAIL illegal_word_rdata: got %h want cafefe0b", rdata); end
        do_xfer(1'b1, 8'hFC, 2'b10, 1'b0, 32'h0, 40);
        checks++; if (rdata !== 32'hFCFD_FEFF || x_err !== 1'b0) begin
            errors++; $display("FAIL edge_word_fc: got %h err=%b want fcfdfeff 0", rdata, x_err);
        end
        do_xfer(1'b1, 8'hFF, 2'b00, 1'b1, 32'h0, 40);
        checks++; if (rdata !== 32'hFFFF_FFFF || x_err !== 1'b0) begin
            errors++; $display("FAIL edge_byte_ff: got %h err=%b want ffffffff 0", rdata, x_err);
        end
        do_xfer(1'b1, 8'hFF, 2'b01, 1'b0, 32'h0, 10);
        checks++; if (x_err !== 1'b1 || rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL illegal_half_ff: got err=%b rdata=%h want 1 ffffffff", x_err, rdata);
        end
    endtask

    task automatic test_slow();
        mode = 1;
        do_xfer(1'b1, 8'h20, 2'b10, 1'b0, 32'h0, 40);
        mode = 0;
        checks++; if (x_lat != 13) begin errors++; $display("FAIL slow_latency: got %0d want 13", x_lat); end
        checks++; if (x_busy_ok !== 1'b1) begin errors++; $display("FAIL slow_busy: got %b want 1", x_busy_ok); end
        checks++; if (rdata !== 32'h2021_2223 || x_err !== 1'b0) begin
            errors++; $display("FAIL slow_data: got %h err=%b want 20212223 0", rdata, x_err);
        end
    endtask

    task automatic test_hang();
        mode = 2;
`ifdef MEM_TIMEOUT_EN
        do_xfer(1'b1, 8'h30, 2'b10, 1'b0, 32'h0, 40);
        checks++; if (x_lat != 19 || x_err !== 1'b1) begin
            errors++; $display("FAIL timeout: got lat=%0d err=%b want 19 1", x_lat, x_err);
        end
        checks++; if (rdata !== 32'h2021_2223) begin errors++; $display("FAIL timeout_rdata: got %h want 20212223", rdata); end
`else
        req = 1'b1; rw = 1'b1; addr = 8'h30; size = 2'b10; ld_signed = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b1 || mfa !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL no_timeout_hang: got busy=%b mfa=%b done=%b want 1 1 0", busy, mfa, done);
        end
        apply_reset();
`endif
        mode = 0;
    endtask

    task automatic test_reset_mid();
        mode = 2;
        req = 1'b1; rw = 1'b1; addr = 8'h40; size = 2'b00; ld_signed = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checks++; if (mfa !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_access: got mfa=%b busy=%b want 1 1", mfa, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mfa !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL async_reset: got mfa=%b busy=%b done=%b want 0 0 0", mfa, busy, done);
        end
        checks++; if (mem_rw !== 1'b1 || mem_addr !== 8'h00 || rdata !== 32'h0) begin
            errors++; $display("FAIL async_reset_regs: got rw=%b addr=%h rdata=%h want 1 00 0", mem_rw, mem_addr, rdata);
        end
        mode = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b want 0", busy); end
        do_xfer(1'b1, 8'h05, 2'b00, 1'b0, 32'h0, 40);
        checks++; if (rdata !== 32'h0000_0005 || x_lat != 4) begin
            errors++; $display("FAIL post_reset_read: got %h lat=%0d want 00000005 4", rdata, x_lat);
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; rw = 1'b1; addr = '0; size = '0;
        ld_signed = 1'b0; wdata = '0;
        test_reset();
        test_word();
        test_half_byte();
        test_illegal();
        test_slow();
        test_hang();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
